// File: rtl/banco_reg.sv
// rtl/banco_reg.sv - 2**N x ANCHO register file, one synchronous write port, two combinational read ports
module banco_reg #(
    parameter int ANCHO = 32,
    parameter int N     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N-1:0]     addr_rd,
    input  logic [ANCHO-1:0] data_in,
    input  logic [N-1:0]     addr_rs1,
    input  logic [N-1:0]     addr_rs2,
    output logic [ANCHO-1:0] rs1,
    output logic [ANCHO-1:0] rs2
);

    localparam int NREG = 2**N;

    logic [ANCHO-1:0] mem_q [NREG];
    logic [ANCHO-1:0] mem_d [NREG];

    // Register 0 is ordinary storage, so every address takes the write.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (we) begin
            mem_d[addr_rd] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // No write bypass: reads see the value stored before the current edge.
    assign rs1 = mem_q[addr_rs1];
    assign rs2 = mem_q[addr_rs2];

endmodule

// File: tb/tb_banco_reg.sv
// tb/tb_banco_reg.sv - randomized scoreboard bench for banco_reg
module tb_banco_reg;

    localparam int ANCHO = 32;
    localparam int N     = 5;
    localparam int NREG  = 2**N;

    logic             clk;
    logic             rst;
    logic             we;
    logic [N-1:0]     addr_rd;
    logic [ANCHO-1:0] data_in;
    logic [N-1:0]     addr_rs1;
    logic [N-1:0]     addr_rs2;
    logic [ANCHO-1:0] rs1;
    logic [ANCHO-1:0] rs2;

    banco_reg #(.ANCHO(ANCHO), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .addr_rd  (addr_rd),
        .data_in  (data_in),
        .addr_rs1 (addr_rs1),
        .addr_rs2 (addr_rs2),
        .rs1      (rs1),
        .rs2      (rs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ANCHO-1:0] e1;
        logic [ANCHO-1:0] e2;
        string            tag;
    } exp_t;

    exp_t             exp_q[$];
    int               n_push = 0;
    int               n_pop  = 0;
    int               checks = 0;
    int               errors = 0;
    logic [ANCHO-1:0] model [NREG];

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) model[i] = '0;
    endtask

    // Expected read-port values come from the reference array, not the DUT.
    task automatic expect_reads(input string tag);
        exp_t e;
        e.e1  = model[addr_rs1];
        e.e2  = model[addr_rs2];
        e.tag = tag;
        exp_q.push_back(e);
        n_push++;
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            wait (n_push > n_pop);
            #1;
            e = exp_q.pop_front();
            n_pop++;
            checks++;
            if (rs1 !== e.e1) begin
                errors++;
                $display("FAIL %s rs1 addr=%0d got=%h exp=%h t=%0t", e.tag, addr_rs1, rs1, e.e1, $time);
            end
            checks++;
            if (rs2 !== e.e2) begin
                errors++;
                $display("FAIL %s rs2 addr=%0d got=%h exp=%h t=%0t", e.tag, addr_rs2, rs2, e.e2, $time);
            end
        end
    end

    initial begin : stimulus
        int budget;
        rst      = 1'b0;
        we       = 1'b0;
        addr_rd  = '0;
        data_in  = '0;
        addr_rs1 = '0;
        addr_rs2 = '0;
        model_clear();

        // Reset held: random write attempts must be ignored, all reads zero.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            we       = 1'($urandom_range(0, 1));
            addr_rd  = N'($urandom);
            data_in  = $urandom;
            addr_rs1 = N'($urandom);
            addr_rs2 = N'($urandom);
            expect_reads("reset_hold");
        end

        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;
        expect_reads("reset_release");

        // Walking-one fill with low-address reads observing progress.
        for (int i = 0; i < NREG; i++) begin
            @(negedge clk);
            we       = 1'b1;
            addr_rd  = N'(i);
            data_in  = 32'h1 << i;
            addr_rs1 = N'($urandom_range(0, 4));
            addr_rs2 = N'($urandom_range(0, 4));
            expect_reads("fill_pre");
            @(posedge clk);
            model[i] = 32'h1 << i;
            #1;
            addr_rs1 = N'(i);
            addr_rs2 = N'($urandom_range(0, 4));
            expect_reads("fill_post");
        end

        // we=0 leaves register 5 untouched.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            we       = 1'b0;
            addr_rd  = 5'd5;
            data_in  = 32'hDEAD_BEEF;
            addr_rs1 = 5'd5;
            addr_rs2 = N'($urandom);
            @(posedge clk);
            #1;
            expect_reads("we0_hold");
        end

        // Read-during-write: old value before the edge, new value after.
        @(negedge clk);
        we       = 1'b1;
        addr_rd  = 5'd7;
        data_in  = 32'h1234_5678;
        addr_rs1 = 5'd7;
        addr_rs2 = 5'd7;
        expect_reads("rdw_before");
        @(posedge clk);
        model[7] = 32'h1234_5678;
        #1;
        expect_reads("rdw_after");

        // Random traffic, including writes to register 0.
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            we       = 1'($urandom_range(0, 1));
            addr_rd  = (c % 8 == 0) ? 5'd0 : N'($urandom);
            data_in  = $urandom;
            addr_rs1 = N'($urandom);
            addr_rs2 = addr_rd;
            expect_reads("rand_pre");
            @(posedge clk);
            if (we) model[addr_rd] = data_in;
            #1;
            expect_reads("rand_post");
        end

        // Asynchronous reset between edges, then a write attempt while held.
        @(negedge clk);
        we       = 1'b0;
        addr_rs1 = 5'd31;
        addr_rs2 = 5'd7;
        #1;
        rst = 1'b0;
        model_clear();
        expect_reads("async_reset");
        we       = 1'b1;
        addr_rd  = 5'd3;
        data_in  = 32'hCAFE_F00D;
        addr_rs1 = 5'd3;
        addr_rs2 = 5'd0;
        @(posedge clk);
        #1;
        expect_reads("write_in_reset");
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        expect_reads("after_reset");

        budget = 100;
        while (n_pop < n_push && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (n_pop < n_push) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", n_push - n_pop);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
